// File: rtl/piso_pkg.sv
// Shared types for the 4-bit serial shift link transmitter.
// Imported by the PISO transmitter.
package piso_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } piso_state_t;

  localparam int unsigned PISO_WIDTH = 4;

endpackage

// File: rtl/piso_shift_transmitter.sv
// Parallel-in/serial-out transmitter for the serial shift link.
// Word loaded over valid/ready, one bit sent per shift_en.
module piso_shift_transmitter
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH      = PISO_WIDTH,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  piso_state_t      state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             serial_q, serial_d;
  logic             done_q, done_d;

  logic             last_bit;

  function automatic logic head_of(
    input logic [WIDTH-1:0] v
  );
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(
    input logic [WIDTH-1:0] v
  );
    return MSB_FIRST ? {v[WIDTH-2:0], 1'b0}
                     : {1'b0, v[WIDTH-1:1]};
  endfunction

  assign last_bit = (state_q == SHIFT) &&
                    (cnt_q == CNT_ONE) &&
                    shift_en;

  // A new word may enter in IDLE or as the last bit leaves.
  assign load_ready = (state_q == IDLE) || last_bit;

  assign serial_out   = serial_q;
  assign serial_valid = (state_q == SHIFT);
  assign busy         = (state_q == SHIFT);
  assign frame_done   = done_q;

  // Next-state: load, shift, last-bit reload or return to idle.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_valid) begin
          shift_d = load_data;
          cnt_d   = CNT_FULL;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          shift_d = advance(shift_q);
          cnt_d   = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            done_d = 1'b1;
            if (load_valid) begin
              shift_d = load_data;
              cnt_d   = CNT_FULL;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    serial_d = (state_d == SHIFT) ? head_of(shift_d)
                                  : IDLE_LEVEL;
  end

  // State, datapath and registered serial outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      serial_q <= IDLE_LEVEL;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      serial_q <= serial_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_piso_shift_transmitter.sv
// Self-checking bench for piso_shift_transmitter.
// Directed vector table plus hand-written corner sequences.
module tb_piso_shift_transmitter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       load_valid = 1'b0;
  logic       load_valid_l = 1'b0;
  logic [3:0] load_data = 4'h0;
  logic       shift_en = 1'b0;

  logic load_ready, serial_out, serial_valid;
  logic busy, frame_done;
  logic load_ready_l, serial_out_l, serial_valid_l;
  logic busy_l, frame_done_l;

  logic [3:0] sipo;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  piso_shift_transmitter #(
    .WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .shift_en(shift_en),
    .serial_out(serial_out), .serial_valid(serial_valid),
    .busy(busy), .frame_done(frame_done)
  );

  piso_shift_transmitter #(
    .WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)
  ) dut_l (
    .clk(clk), .reset_n(reset_n),
    .load_valid(load_valid_l), .load_ready(load_ready_l),
    .load_data(load_data), .shift_en(shift_en),
    .serial_out(serial_out_l), .serial_valid(serial_valid_l),
    .busy(busy_l), .frame_done(frame_done_l)
  );

  // Receiving SIPO on the link: shifts in at the LSB.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sipo <= 4'h0;
    else if (shift_en && serial_valid)
      sipo <= {sipo[2:0], serial_out};
  end

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       sh;
    logic       rdy;
    logic       so;
    logic       sv;
    logic       fd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(logic v, logic [3:0] d,
                              logic sh, logic rdy,
                              logic so, logic sv,
                              logic fd);
    vec_t r;
    r.v = v; r.d = d; r.sh = sh; r.rdy = rdy;
    r.so = so; r.sv = sv; r.fd = fd;
    return r;
  endfunction

  task automatic drive(input logic v, input logic [3:0] d,
                       input logic sh);
    @(negedge clk);
    load_valid = v;
    load_data = d;
    shift_en = sh;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    load_valid = 1'b0;
    load_valid_l = 1'b0;
    shift_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Test 1: 4'b1011, shift_en held high
    vecs.push_back(mk(1, 4'hB, 1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 4'h0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 4'h0, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 4'h0, 1, 1, 0, 0, 1));
    vecs.push_back(mk(0, 4'h0, 1, 1, 0, 0, 0));
    // Test 3: 4'b1001, shift_en 1,0,0,1,1,1
    vecs.push_back(mk(1, 4'h9, 0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 4'h0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 4'h0, 1, 1, 0, 0, 1));
    vecs.push_back(mk(0, 4'h0, 0, 1, 0, 0, 0));
    // Test 4: back-to-back 4'hA then 4'h5
    vecs.push_back(mk(1, 4'hA, 1, 1, 1, 1, 0));
    vecs.push_back(mk(1, 4'h5, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 4'h5, 1, 0, 1, 1, 0));
    vecs.push_back(mk(1, 4'h5, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 4'h5, 1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 4'h0, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 4'h0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 4'h0, 1, 1, 0, 0, 1));
    vecs.push_back(mk(0, 4'h0, 1, 1, 0, 0, 0));
    // Test 5: stray load mid-frame is refused
    vecs.push_back(mk(1, 4'hB, 1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 4'h0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 4'h6, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 4'h0, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 4'h0, 1, 1, 0, 0, 1));
    vecs.push_back(mk(0, 4'h0, 1, 1, 0, 0, 0));

    // Reset values while held in reset
    #2;
    chk("rst_ready", load_ready, 1);
    chk("rst_serial", serial_out, 0);
    chk("rst_valid", serial_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post_rst_ready", load_ready, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].sh);
      #1;
      chk($sformatf("v%0d_ready", i), load_ready, vecs[i].rdy);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_serial", i), serial_out, vecs[i].so);
      chk($sformatf("v%0d_valid", i), serial_valid, vecs[i].sv);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].sv);
      chk($sformatf("v%0d_done", i), frame_done, vecs[i].fd);
    end

    // Test 2: loopback into the SIPO
    do_reset();
    drive(1, 4'hB, 1);
    for (int k = 0; k < 4; k++) drive(0, 4'h0, 1);
    drive(0, 4'h0, 0);
    #1;
    chk("loopback_sipo", sipo, 4'hB);
    chk("loopback_idle", busy, 0);

    // Test 6: reset during bit 3 aborts the frame
    do_reset();
    drive(1, 4'hB, 1);
    drive(0, 4'h0, 1);
    drive(0, 4'h0, 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_serial", serial_out, 0);
    chk("abort_valid", serial_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", frame_done, 0);
    chk("abort_ready", load_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("abort_nodone%0d", k), frame_done, 0);
      chk($sformatf("abort_idle%0d", k), busy, 0);
    end

    // LSB-first build: 4'b0001 -> 1,0,0,0
    do_reset();
    @(negedge clk);
    load_valid_l = 1'b1;
    load_data = 4'h1;
    shift_en = 1'b1;
    @(negedge clk);
    load_valid_l = 1'b0;
    chk("lsb_b0", serial_out_l, 1);
    chk("lsb_v0", serial_valid_l, 1);
    @(negedge clk);
    chk("lsb_b1", serial_out_l, 0);
    @(negedge clk);
    chk("lsb_b2", serial_out_l, 0);
    @(negedge clk);
    chk("lsb_b3", serial_out_l, 0);
    chk("lsb_v3", busy_l, 1);
    chk("lsb_ready_last", load_ready_l, 1);
    @(negedge clk);
    chk("lsb_done", frame_done_l, 1);
    chk("lsb_idle", serial_valid_l, 0);
    chk("lsb_ready", load_ready_l, 1);
    shift_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
